// File: rtl/serial_adder_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder/subtractor.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int calc_ndig(input int width, input int digit);
    return width / digit;
  endfunction

  function automatic int calc_cnt_w(input int ndig);
    return (ndig <= 1) ? 1 : $clog2(ndig);
  endfunction

  function automatic bit width_ok(input int width, input int digit);
    return (digit >= 1) && (digit <= width) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/serial_adder_digit_adder.sv
// Combinational DIGIT-bit ripple-carry slice; the only carry chain in the adder.
module digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout
);

  logic w_c;

  always_comb begin
    sum = '0;
    w_c = cin;
    for (int i = 0; i < DIGIT; i++) begin
      sum[i] = a[i] ^ b[i] ^ w_c;
      w_c    = (a[i] & b[i]) | (w_c & (a[i] ^ b[i]));
    end
    cout = w_c;
  end

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: operands shift through one DIGIT-bit slice,
// LSB digit first, and the finished result is published in output registers.
//   state | meaning
//   IDLE  | waiting for operands, in_ready high
//   RUN   | one digit per cycle through the ripple slice
//   DONE  | result held until out_ready
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG  = calc_ndig(WIDTH, DIGIT);
  localparam int CNT_W = calc_cnt_w(NDIG);

  if (!width_ok(WIDTH, DIGIT)) begin : g_bad_params
    $error("serial_adder: WIDTH must be a positive multiple of DIGIT");
  end

  state_t             r_state;
  logic [WIDTH-1:0]   r_op_a;
  logic [WIDTH-1:0]   r_op_b;
  logic [WIDTH-1:0]   r_shift;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               r_ovf;
  logic               r_out_valid;

  logic [DIGIT-1:0]   w_dsum;
  logic               w_dcout;
  logic [WIDTH-1:0]   w_shift_next;
  logic               w_last;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a    (r_op_a[DIGIT-1:0]),
    .b    (r_op_b[DIGIT-1:0]),
    .cin  (r_carry),
    .sum  (w_dsum),
    .cout (w_dcout)
  );

  // New digit enters at the top so the LSB digit lands at bit 0 after NDIG shifts.
  if (NDIG == 1) begin : g_single
    assign w_shift_next = w_dsum;
  end else begin : g_multi
    assign w_shift_next = {w_dsum, r_shift[WIDTH-1:DIGIT]};
  end

  assign w_last    = (r_cnt == CNT_W'(NDIG - 1));
  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_shift     <= '0;
      r_carry     <= 1'b0;
      r_cnt       <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_op_a  <= a;
            r_op_b  <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : cin;
            r_cnt   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_op_a  <= r_op_a >> DIGIT;
          r_op_b  <= r_op_b >> DIGIT;
          r_shift <= w_shift_next;
          r_carry <= w_dcout;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (w_last) begin
            // On the last digit the low slice of each operand holds its original MSB.
            r_sum       <= w_shift_next;
            r_cout      <= w_dcout;
            r_ovf       <= (r_op_a[DIGIT-1] == r_op_b[DIGIT-1]) &&
                           (w_dsum[DIGIT-1] != r_op_a[DIGIT-1]);
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed vectors, random ops against an
// arithmetic model, backpressure, mid-run reset and a single-digit instance.
module tb_serial_adder;

  logic        clk;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] a, b, sum;
  logic        cin, sub, cout, ovf;

  logic        in_valid2, in_ready2, out_valid2, out_ready2;
  logic [7:0]  a2, b2, sum2;
  logic        cin2, sub2, cout2, ovf2;

  int total = 0;
  int bad   = 0;

  serial_adder #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  serial_adder #(.WIDTH(8), .DIGIT(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .cin(cin2), .sub(sub2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .sum(sum2), .cout(cout2), .ovf(ovf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        c;
    logic        o;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic; overflow is the exact signed result leaving 16-bit range.
  function automatic void model(input logic [15:0] x, input logic [15:0] y,
                                input logic ci, input logic sb,
                                output logic [15:0] s, output logic c, output logic o);
    int sx, sy, sv;
    logic [16:0] u;
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (sb) begin
      u  = {1'b0, x} - {1'b0, y};
      c  = (x >= y);
      sv = sx - sy;
    end else begin
      u  = {1'b0, x} + {1'b0, y} + {16'd0, ci};
      c  = u[16];
      sv = sx + sy + (ci ? 1 : 0);
    end
    s = u[15:0];
    o = (sv > 32767) || (sv < -32768);
  endfunction

  task automatic run_op(input logic [15:0] xa, input logic [15:0] xb,
                        input logic xci, input logic xsb,
                        output logic [15:0] s, output logic c, output logic o,
                        output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) chk("ready_timeout", 32'(n), 32'd0);
    a = xa; b = xb; cin = xci; sub = xsb; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    s = sum; c = cout; o = ovf;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] rs, es, held;
    logic        rc, ro, ec, eo;
    int          lat, n;

    vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{16'h0001, 16'h0001, 1'b1, 1'b0, 16'h0003, 1'b0, 1'b0};
    vecs[6] = '{16'h0003, 16'h0003, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};

    rst = 1'b1;
    in_valid = 0; out_ready = 0; a = 0; b = 0; cin = 0; sub = 0;
    in_valid2 = 0; out_ready2 = 0; a2 = 0; b2 = 0; cin2 = 0; sub2 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout_ovf", {30'd0, cout, ovf}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, rs, rc, ro, lat);
      chk($sformatf("vec%0d_sum", i), 32'(rs), 32'(vecs[i].s));
      chk($sformatf("vec%0d_cout", i), 32'(rc), 32'(vecs[i].c));
      chk($sformatf("vec%0d_ovf", i), 32'(ro), 32'(vecs[i].o));
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd4);
      chk($sformatf("vec%0d_ready_after", i), 32'(in_ready), 32'd1);
    end

    for (int i = 0; i < 40; i++) begin
      logic [15:0] xa, xb;
      logic        xci, xsb;
      xa  = 16'($urandom);
      xb  = 16'($urandom);
      xci = 1'($urandom);
      xsb = 1'($urandom);
      model(xa, xb, xci, xsb, es, ec, eo);
      run_op(xa, xb, xci, xsb, rs, rc, ro, lat);
      chk($sformatf("rnd%0d_sum", i), 32'(rs), 32'(es));
      chk($sformatf("rnd%0d_cout", i), 32'(rc), 32'(ec));
      chk($sformatf("rnd%0d_ovf", i), 32'(ro), 32'(eo));
      chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'd4);
    end

    // Backpressure with stray in_valid pulses during RUN and DONE.
    a = 16'h1111; b = 16'h2222; cin = 0; sub = 0; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 16'h0F0F; b = 16'h0F0F;
    chk("bp_ready_run", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("bp_lat", 32'(n), 32'd4);
    for (int k = 0; k < 5; k++) begin
      in_valid = (k == 2);
      chk($sformatf("bp_hold%0d_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("bp_hold%0d_sum", k), 32'(sum), 32'h3333);
      chk($sformatf("bp_hold%0d_flags", k), {30'd0, cout, ovf}, 32'd0);
      chk($sformatf("bp_hold%0d_ready", k), 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_consumed_valid", 32'(out_valid), 32'd0);
    chk("bp_consumed_ready", 32'(in_ready), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    chk("bp_no_queue_valid", 32'(out_valid), 32'd0);
    chk("bp_no_queue_ready", 32'(in_ready), 32'd1);
    chk("bp_result_held", 32'(sum), 32'h3333);

    // Reset two cycles into RUN discards the operation and clears outputs.
    held = sum;
    a = 16'h4444; b = 16'h1111; cin = 0; sub = 0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_run_ready", 32'(in_ready), 32'd0);
    chk("mid_run_sum_held", 32'(sum), 32'(held));
    rst = 1'b1;
    #1;
    chk("arst_ready", 32'(in_ready), 32'd1);
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_sum", 32'(sum), 32'd0);
    chk("arst_flags", {30'd0, cout, ovf}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, rs, rc, ro, lat);
    chk("post_rst_sum", 32'(rs), 32'h0100);
    chk("post_rst_flags", {30'd0, rc, ro}, 32'd0);
    chk("post_rst_lat", 32'(lat), 32'd4);

    // Single-digit instance: one RUN cycle.
    a2 = 8'h80; b2 = 8'h80; cin2 = 0; sub2 = 0;
    chk("w8_ready", 32'(in_ready2), 32'd1);
    in_valid2 = 1'b1;
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    chk("w8_ready_busy", 32'(in_ready2), 32'd0);
    chk("w8_valid_k0", 32'(out_valid2), 32'd0);
    @(posedge clk); #1;
    chk("w8_valid_k1", 32'(out_valid2), 32'd1);
    chk("w8_sum", 32'(sum2), 32'h00);
    chk("w8_cout", 32'(cout2), 32'd1);
    chk("w8_ovf", 32'(ovf2), 32'd1);
    out_ready2 = 1'b1;
    @(posedge clk); #1;
    out_ready2 = 1'b0;
    chk("w8_consumed", 32'(in_ready2), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
